axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI4 read channel (AR+R) between ICache refill (requester 0) and DCache refill/uncached read (requester 1).
//  Sits between the two cache AXI masters and the CPU top-level AXI port; one outstanding burst at a time, lock-on-grant to RLAST.
//  Tags ARID with requester index; routes R beats back to the granted requester only.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  read data width
//  ID_W     4   ARID/RID width; requester index zero-extended
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active-high
//  req_arvalid  in   2        per-requester AR valid ([0]=I$, [1]=D$)
//  req_araddr   in   2xADDR_W per-requester address
//  req_arlen    in   2x8      per-requester burst length-1
//  req_arsize   in   2x3      per-requester beat size
//  req_arready  out  2        AR accepted for that requester
//  req_rvalid   out  2        R beat valid for that requester
//  req_rready   in   2        requester accepts R beat
//  req_rdata    out  DATA_W   shared R data (qualify with req_rvalid)
//  req_rresp    out  2        shared R resp
//  req_rlast    out  1        shared R last
//  arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/ADDR_W/8/3/2/1  downstream AR
//  arready      in   1        downstream AR ready
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  downstream R
//  rready       out  1        downstream R ready
//  grant        out  2        one-hot current owner, 0 in IDLE
//  busy         out  1        state != IDLE
//  proto_err    out  1        sticky: RID mismatch or RLAST/beat-count mismatch
// BEHAVIOUR
//  FSM IDLE -> ADDR -> DATA -> IDLE; state, grant, beat counter, proto_err registered.
//  Reset: state=IDLE, grant=0, busy=0, arvalid=0, rready=0, req_arready=0, req_rvalid=0, proto_err=0, last-grant=requester 0.
//  IDLE: if any req_arvalid, pick winner, register grant, go ADDR; no AR driven this cycle (1-cycle arbitration latency).
//  Pick: fixed priority, D$ (1) over I$ (0).
//  ADDR: araddr/arlen/arsize from granted requester (combinational mux), arburst=INCR, arid=grant index,
//   arvalid=req_arvalid[g]; req_arready[g]=arready; on arvalid&arready load beat counter=arlen, go DATA.
//   Granted req_arvalid drops before handshake (abort): return IDLE, no AR issued.
//  DATA: req_rvalid[g]=rvalid, rready=req_rready[g]; ungranted requester sees rvalid=0, arready=0.
//   Each rvalid&rready beat: counter-1; rlast with counter!=0, or counter==0 without rlast, or rid!=grant -> set proto_err.
//   rvalid&rready&rlast -> IDLE next cycle, grant=0; new grant earliest one cycle later (no back-to-back same-cycle regrant).
//  arlen=0: single beat, counter 0, first beat must carry rlast.
//  Requester re-asserting arvalid while in DATA is held (arready=0) until next IDLE.
//  rst mid-burst: FSM to IDLE immediately; in-flight downstream beats after reset are the system's concern (whole SoC resets together).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; on simultaneous request the requester not granted last wins; last-grant updated on AR handshake.
//  ARB_RR_EN undefined: fixed D$-over-I$ priority, last-grant register not instantiated.
// STRUCTURE
//  Package axi_arb_pkg: arb_state_e {IDLE,ADDR,DATA}, AXI_BURST_INCR=2'b01, ARID_ICACHE=0, ARID_DCACHE=1, ARB_N=2.
//  Sub-module arb_picker: 2-way request vector + last-grant -> one-hot winner (fixed or RR per ARB_RR_EN).
//  Top holds FSM, beat counter, AR/R muxing, error flag.
// TESTING
//  I$ only, addr 0xBFC00200 arlen=7 -> arid=0, 8 beats to req_rvalid[0], grant=01 throughout, IDLE after rlast.
//  I$+D$ same cycle (fixed) -> D$ first (arid=1, addr 0x80001000 arlen=3), then I$ granted 1 cycle after D$ rlast.
//  I$+D$ both persistently requesting with ARB_RR_EN -> grants alternate 10,01,10 ...
//  arlen=0 with rlast on beat 1 -> no proto_err; arlen=3 with rlast on beat 2 -> proto_err=1, sticky until rst.
//  arready held low 5 cycles in ADDR -> araddr/arid stable, arvalid=1, req_arready=0 until handshake.
//  rst asserted mid-DATA beat 2 -> next cycle busy=0, grant=0, rready=0, proto_err=0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned ARID_ICACHE    = 0;
  localparam int unsigned ARID_DCACHE    = 1;
  localparam int unsigned ARB_N          = 2;

endpackage

// File: rtl/arb_picker.sv
// Two-way request picker: request vector plus last-grant index -> one-hot winner.
// ARB_RR_EN defined: round-robin on collision; undefined: D$ (1) over I$ (0).
module arb_picker
  import axi_arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic             last,
  output logic [ARB_N-1:0] win
);

`ifdef ARB_RR_EN
  // On a collision the requester that was not granted last wins.
  always_comb begin
    win = req;
    if (req[ARID_DCACHE] && req[ARID_ICACHE]) begin
      win = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: D$ always beats I$.
  always_comb begin
    win = '0;
    if (req[ARID_DCACHE]) begin
      win = 2'b10;
    end else if (req[ARID_ICACHE]) begin
      win = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel (AR+R) between I$ (requester 0) and D$ (requester 1).
// One outstanding burst, grant locked until RLAST; ARID carries the requester index.
// ARB_RR_EN selects round-robin arbitration instead of fixed D$-over-I$ priority.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // Requester side
  input  logic [ARB_N-1:0]              req_arvalid,
  input  logic [ARB_N-1:0][ADDR_W-1:0]  req_araddr,
  input  logic [ARB_N-1:0][7:0]         req_arlen,
  input  logic [ARB_N-1:0][2:0]         req_arsize,
  output logic [ARB_N-1:0]              req_arready,
  output logic [ARB_N-1:0]              req_rvalid,
  input  logic [ARB_N-1:0]              req_rready,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [1:0]                    req_rresp,
  output logic                          req_rlast,
  // Downstream AR
  output logic [ID_W-1:0]               arid,
  output logic [ADDR_W-1:0]             araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  // Downstream R
  input  logic [ID_W-1:0]               rid,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready,
  // Status
  output logic [ARB_N-1:0]              grant,
  output logic                          busy,
  output logic                          proto_err
);

  arb_state_e       state_q, state_d;
  logic [ARB_N-1:0] grant_q, grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [ARB_N-1:0] win;
  logic             last_grant;
  logic             gsel;
  logic             beat;
  logic             beat_bad;

  // Grant is one-hot, so bit 1 is the granted requester index.
  assign gsel = grant_q[ARID_DCACHE];

`ifdef ARB_RR_EN
  logic last_q, last_d;
  assign last_grant = last_q;
`else
  assign last_grant = 1'b0;
`endif

  arb_picker u_picker (
    .req  (req_arvalid),
    .last (last_grant),
    .win  (win)
  );

  assign beat     = rvalid && req_rready[gsel];
  assign beat_bad = (rlast && (cnt_q != 8'd0)) || (!rlast && (cnt_q == 8'd0)) ||
                    (rid != ID_W'(gsel));

  // Next-state logic and channel muxing.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef ARB_RR_EN
    last_d      = last_q;
`endif
    arvalid     = 1'b0;
    rready      = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    araddr      = req_araddr[gsel];
    arlen       = req_arlen[gsel];
    arsize      = req_arsize[gsel];
    arburst     = AXI_BURST_INCR;
    arid        = ID_W'(gsel);

    unique case (state_q)
      IDLE: begin
        // Register the winner only; AR goes out next cycle.
        if (|req_arvalid) begin
          grant_d = win;
          state_d = ADDR;
        end
      end
      ADDR: begin
        arvalid           = req_arvalid[gsel];
        req_arready[gsel] = arready;
        if (!req_arvalid[gsel]) begin
          // Requester withdrew before the handshake: nothing was issued.
          state_d = IDLE;
          grant_d = '0;
        end else if (arready) begin
          cnt_d   = req_arlen[gsel];
          state_d = DATA;
`ifdef ARB_RR_EN
          last_d  = gsel;
`endif
        end
      end
      DATA: begin
        req_rvalid[gsel] = rvalid;
        rready           = req_rready[gsel];
        if (beat) begin
          cnt_d = cnt_q - 8'd1;
          if (beat_bad) begin
            err_d = 1'b1;
          end
          if (rlast) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, beat counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef ARB_RR_EN
  // Last-granted requester, updated on the AR handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign req_rdata = rdata;
  assign req_rresp = rresp;
  assign req_rlast = rlast;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = err_q;

endmodule
